serial_word_feeder: RTL and testbench

Parallel-to-serial feeder sitting directly upstream of the bidirectional shift register. Accepts a W-bit word plus a direction flag over a valid/ready handshake and drives the shift register's serial data, enable and direction inputs for exactly W enabled cycles. After the last shift, the downstream register holds the accepted word bit-for-bit. Completion is signalled with a one-cycle `done` pulse, and a `stall` input pauses shifting without losing position.

---
 rtl/serial_word_feeder_if.sv | 29 ++
 rtl/serial_word_feeder.sv | 77 +++++++
 tb/tb_serial_word_feeder.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_word_feeder_if.sv
// Handshake and serial-drive bundle between an upstream word source, the feeder
// and the downstream bidirectional shift register.
interface serial_word_feeder_if #(
  parameter int W = 4
);
  // A word moves only on a clock edge where in_valid && in_ready are both high.
  // in_data/in_dir need only be stable while in_valid is high. in_ready does not
  // depend on in_valid, so a source may wait for in_ready before raising in_valid.
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         in_dir;
  logic         stall;
  logic         sh_d;
  logic         sh_en;
  logic         sh_dir;
  logic         busy;
  logic         done;

  modport master (
    output in_valid, in_data, in_dir, stall,
    input  in_ready, sh_d, sh_en, sh_dir, busy, done
  );

  modport slave (
    input  in_valid, in_data, in_dir, stall,
    output in_ready, sh_d, sh_en, sh_dir, busy, done
  );
endinterface

// File: rtl/serial_word_feeder.sv
// Serializes one W-bit word into a downstream bidirectional shift register.
// Bit order follows the direction flag so the register ends up holding the word.
module serial_word_feeder #(
  parameter int W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_word_feeder_if.slave  bus,
  output logic [1:0]           dbg_state
);
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state;
  logic [W-1:0]  word;
  logic          dir_q;
  logic [CW-1:0] cnt;
  logic          accept;

  assign accept = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      word  <= '0;
      dir_q <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            word  <= bus.in_data;
            dir_q <= bus.in_dir;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          // A stalled cycle freezes everything, so position is never lost.
          if (!bus.stall) begin
            if (cnt == CW'(W - 1)) begin
              state <= DONE;
            end else begin
              cnt  <= cnt + 1'b1;
              word <= dir_q ? (word >> 1) : (word << 1);
            end
          end
        end
        DONE: begin
          if (accept) begin
            word  <= bus.in_data;
            dir_q <= bus.in_dir;
            cnt   <= '0;
            state <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // MSB leads when the downstream shifts toward MSB, LSB leads otherwise.
  assign bus.sh_d     = dir_q ? word[0] : word[W-1];
  assign bus.sh_en    = (state == SHIFT) && !bus.stall;
  assign bus.sh_dir   = dir_q;
  assign bus.busy     = (state == SHIFT);
  assign bus.done     = (state == DONE);
  assign bus.in_ready = (state != SHIFT);
  assign dbg_state    = state;
endmodule

// File: tb/tb_serial_word_feeder.sv
// Bench for serial_word_feeder: queue-based model of the bit stream, a modelled
// downstream shift register, and directed word scenarios with literal expectations.
module tb_serial_word_feeder;
  localparam int W = 4;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;

  serial_word_feeder_if #(.W(W)) bus();

  serial_word_feeder #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checking helpers ----------------
  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Downstream bidirectional shift register fed by the DUT.
  logic [W-1:0] ds_q = '0;
  always @(posedge clk) begin
    if (bus.sh_en) begin
      if (bus.sh_dir) ds_q <= {bus.sh_d, ds_q[W-1:1]};
      else            ds_q <= {ds_q[W-2:0], bus.sh_d};
    end
  end

  // ---------------- behavioural model ----------------
  // A word in flight is just the list of bits still to present.
  bit           m_bits[$];
  logic         m_dir  = 1'b0;
  logic         m_done = 1'b0;
  logic [W-1:0] exp_q[$];
  logic         m_busy, m_acc, m_pop;

  function automatic void model_clear();
    m_bits.delete();
    exp_q.delete();
    m_dir  = 1'b0;
    m_done = 1'b0;
  endfunction

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        model_clear();
      end else begin
        m_busy = (m_bits.size() != 0);
        m_acc  = bus.in_valid && !m_busy;
        m_pop  = m_busy && !bus.stall;
        if (m_pop) void'(m_bits.pop_front());
        m_done = m_pop && (m_bits.size() == 0);
        if (m_acc) begin
          m_dir = bus.in_dir;
          for (int i = 0; i < W; i++)
            m_bits.push_back(bus.in_dir ? bus.in_data[i] : bus.in_data[W-1-i]);
          exp_q.push_back(bus.in_data);
        end
      end
    end
  end

  // ---------------- compare process + observation ----------------
  logic [31:0]  obs_seq = '0;
  int           obs_n = 0;
  int           done_cnt = 0;
  int           last_done_cyc = 0;
  logic [W-1:0] last_ds = '0;
  int           stall_seen = 0;
  int           bad_ready = 0;
  logic         c_busy;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        c_busy = (m_bits.size() != 0);
        chk("busy",     32'(bus.busy),     32'(c_busy));
        chk("in_ready", 32'(bus.in_ready), 32'(!c_busy));
        chk("sh_en",    32'(bus.sh_en),    32'(c_busy && !bus.stall));
        chk("sh_dir",   32'(bus.sh_dir),   32'(m_dir));
        chk("done",     32'(bus.done),     32'(m_done));
        if (c_busy && !bus.stall) chk("sh_d", 32'(bus.sh_d), 32'(m_bits[0]));
        if (bus.done) begin
          chk("sb_pending", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) chk("ds_word", 32'(ds_q), 32'(exp_q.pop_front()));
          done_cnt++;
          last_done_cyc = cyc;
          last_ds = ds_q;
        end
        if (bus.sh_en) begin
          obs_seq = {obs_seq[30:0], bus.sh_d};
          obs_n++;
        end
        if (bus.busy && !bus.sh_en) stall_seen++;
        if (bus.busy && bus.in_ready) bad_ready++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_obs();
    obs_seq = '0;
    obs_n = 0;
    stall_seen = 0;
    bad_ready = 0;
  endtask

  task automatic send_word(input logic [W-1:0] d, input logic dir, input bit keep,
                           output int acc_cyc);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    bus.in_data  = d;
    bus.in_dir   = dir;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk); #1;
    end
    chk("accept", 32'(ok), 32'd1);
    acc_cyc = cyc;
    if (!keep) bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n0;
    n0 = done_cnt;
    for (int i = 0; i < budget && done_cnt == n0; i++) begin
      @(negedge clk); #1;
    end
    chk("done_seen", 32'(done_cnt - n0), 32'd1);
  endtask

  // ---------------- directed scenarios ----------------
  int a, a2, d1, n0;

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_dir   = 1'b0;
    bus.stall    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sh_d",     32'(bus.sh_d),     32'd0);
    chk("rst_sh_en",    32'(bus.sh_en),    32'd0);
    chk("rst_sh_dir",   32'(bus.sh_dir),   32'd0);
    chk("rst_busy",     32'(bus.busy),     32'd0);
    chk("rst_done",     32'(bus.done),     32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_state",    32'(dbg_state),    32'd0);
    @(negedge clk);
    rst = 1'b0;

    // MSB first, no stall
    clear_obs();
    send_word(4'b1011, 1'b0, 1'b0, a);
    wait_done(20);
    chk("t1_bits",    obs_seq, 32'b1011);
    chk("t1_nbits",   32'(obs_n), 32'd4);
    chk("t1_latency", 32'(last_done_cyc - a), 32'd4);
    chk("t1_ds",      32'(last_ds), 32'b1011);

    // LSB first
    clear_obs();
    send_word(4'b1011, 1'b1, 1'b0, a);
    wait_done(20);
    chk("t2_bits",    obs_seq, 32'b1101);
    chk("t2_latency", 32'(last_done_cyc - a), 32'd4);
    chk("t2_ds",      32'(last_ds), 32'b1011);

    // two stalled cycles after the second bit
    clear_obs();
    send_word(4'b0110, 1'b0, 1'b0, a);
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.stall = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.stall = 1'b0;
    wait_done(20);
    chk("t3_bits",    obs_seq, 32'b0110);
    chk("t3_stalls",  32'(stall_seen), 32'd2);
    chk("t3_latency", 32'(last_done_cyc - a), 32'd6);
    chk("t3_ds",      32'(last_ds), 32'b0110);

    // back-to-back words with in_valid held high
    clear_obs();
    send_word(4'hA, 1'b0, 1'b1, a);
    send_word(4'h5, 1'b0, 1'b0, a2);
    chk("t4_accept_gap", 32'(a2 - a), 32'd5);
    d1 = last_done_cyc;
    chk("t4_first_done", 32'(d1 - a), 32'd4);
    chk("t4_ds_a", 32'(last_ds), 32'hA);
    wait_done(20);
    chk("t4_done_gap", 32'(last_done_cyc - d1), 32'd5);
    chk("t4_ds_5", 32'(last_ds), 32'h5);
    chk("t4_ready_in_shift", 32'(bad_ready), 32'd0);

    // asynchronous reset after two bits of 4'hF
    clear_obs();
    send_word(4'hF, 1'b0, 1'b0, a);
    @(posedge clk); #1;
    @(posedge clk); #1;
    #3;
    chk("t5_pre_sh_en", 32'(bus.sh_en), 32'd1);
    n0 = done_cnt;
    rst = 1'b1;
    #1;
    chk("t5_sh_en", 32'(bus.sh_en),    32'd0);
    chk("t5_busy",  32'(bus.busy),     32'd0);
    chk("t5_ready", 32'(bus.in_ready), 32'd1);
    chk("t5_done",  32'(bus.done),     32'd0);
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    chk("t5_no_done", 32'(done_cnt), 32'(n0));
    clear_obs();
    send_word(4'h3, 1'b1, 1'b0, a);
    wait_done(20);
    chk("t5_bits", obs_seq, 32'b1100);
    chk("t5_ds",   32'(last_ds), 32'h3);

    // in_valid pulse during SHIFT is ignored
    clear_obs();
    send_word(4'b1001, 1'b0, 1'b0, a);
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.in_data  = 4'b0110;
    bus.in_dir   = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    wait_done(20);
    chk("t6_bits",    obs_seq, 32'b1001);
    chk("t6_latency", 32'(last_done_cyc - a), 32'd4);
    chk("t6_ds",      32'(last_ds), 32'b1001);
    n0 = done_cnt;
    repeat (6) @(negedge clk);
    #1;
    chk("t6_no_extra_done", 32'(done_cnt), 32'(n0));
    chk("t6_idle", 32'(bus.busy), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
